// File: rtl/fpga_pulse_generator_pkg.sv
// Shared register map, response codes and write-FSM states for the AXI-Lite pulse generator.
package fpga_pulse_generator_pkg;

  localparam logic [7:0] REG_CTRL        = 8'h00;
  localparam logic [7:0] REG_PERIOD      = 8'h04;
  localparam logic [7:0] REG_WIDTH       = 8'h08;
  localparam logic [7:0] REG_COUNT_LIMIT = 8'h0C;
  localparam logic [7:0] REG_STATUS      = 8'h10;

  localparam int CTRL_ENABLE_BIT = 0;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GOT_AW = 2'd1,
    GOT_W  = 2'd2,
    RESP   = 2'd3
  } wr_state_t;

  typedef enum logic [2:0] {
    SEL_CTRL   = 3'd0,
    SEL_PERIOD = 3'd1,
    SEL_WIDTH  = 3'd2,
    SEL_LIMIT  = 3'd3,
    SEL_STATUS = 3'd4,
    SEL_NONE   = 3'd5
  } reg_sel_t;

endpackage

// File: rtl/fpga_pulse_generator_core.sv
// Pulse engine: registered pulse_out, one cycle behind enable/config; PERIOD/WIDTH reload only at wrap.
// PULSE_GEN_STATUS_EN exposes running flag and completed-period count; no backpressure (free-running).
module fpga_pulse_generator_core #(
  parameter int W = 32
) (
  input  logic         core_clk,
  input  logic         arst_n,
  input  logic         enable,
  input  logic [W-1:0] period,
  input  logic [W-1:0] width,
  input  logic [W-1:0] count_limit,
`ifdef PULSE_GEN_STATUS_EN
  output logic         running,
  output logic [W-2:0] pulse_count,
`endif
  output logic         pulse_out
);
  import fpga_pulse_generator_pkg::*;

  logic         enable_q;
  logic         stopped;
  logic [W-1:0] cnt;
  logic [W-1:0] per_a;
  logic [W-1:0] wid_a;
  logic [W-1:0] periods;
  logic         wrap;
  logic         last_period;

  assign wrap        = (cnt == per_a - W'(1));
  assign last_period = (count_limit != '0) && ((periods + W'(1)) >= count_limit);

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      enable_q  <= 1'b0;
      stopped   <= 1'b0;
      cnt       <= '0;
      per_a     <= '0;
      wid_a     <= '0;
      periods   <= '0;
      pulse_out <= 1'b0;
    end else if (!enable) begin
      enable_q  <= 1'b0;
      stopped   <= 1'b0;
      pulse_out <= 1'b0;
    end else if (!enable_q) begin
      enable_q  <= 1'b1;
      stopped   <= 1'b0;
      cnt       <= '0;
      periods   <= '0;
      per_a     <= period;
      wid_a     <= width;
      pulse_out <= (period != '0) && (width != '0);
    end else if (stopped) begin
      pulse_out <= 1'b0;
    end else if (per_a == '0 || wrap) begin
      // A zero period keeps reloading so a later PERIOD write starts the train.
      cnt   <= '0;
      per_a <= period;
      wid_a <= width;
      if (per_a != '0) begin
        periods <= periods + W'(1);
      end
      if (per_a != '0 && last_period) begin
        stopped   <= 1'b1;
        pulse_out <= 1'b0;
      end else begin
        pulse_out <= (period != '0) && (width != '0);
      end
    end else begin
      cnt       <= cnt + W'(1);
      pulse_out <= (cnt + W'(1)) < wid_a;
    end
  end

`ifdef PULSE_GEN_STATUS_EN
  assign running     = enable_q && !stopped;
  assign pulse_count = periods[W-2:0];
`endif

endmodule

// File: rtl/fpga_pulse_generator_axil_slave.sv
// AXI4-Lite register slave driving the pulse core; write commit and read data one cycle after handshake,
// B/R held until READY. PULSE_GEN_STATUS_EN adds read-only STATUS at 0x10.
module fpga_pulse_generator_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            pulse_out
);
  import fpga_pulse_generator_pkg::*;

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int SW = DW / 8;

  // Holds READY low through reset and for the first clock after it.
  logic           live;
  wr_state_t      wr_state, wr_next;
  logic [AW-3:0]  aw_word_q;
  logic [DW-1:0]  wdata_q;
  logic [SW-1:0]  wstrb_q;
  logic           aw_hs, w_hs, ar_hs, wr_commit;
  logic [AW-3:0]  wr_word;
  logic [DW-1:0]  wr_data;
  logic [SW-1:0]  wr_strb;
  reg_sel_t       wr_sel, rd_sel;
  logic [DW-1:0]  ctrl_q, period_q, width_q, limit_q;
  logic [DW-1:0]  rd_mux;
`ifdef PULSE_GEN_STATUS_EN
  logic           running;
  logic [DW-2:0]  pulse_count;
`endif

  function automatic reg_sel_t decode(input logic [AW-3:0] word);
    logic [AW-1:0] a;
    a = {word, 2'b00};
    if (a == AW'(REG_CTRL))        return SEL_CTRL;
    if (a == AW'(REG_PERIOD))      return SEL_PERIOD;
    if (a == AW'(REG_WIDTH))       return SEL_WIDTH;
    if (a == AW'(REG_COUNT_LIMIT)) return SEL_LIMIT;
`ifdef PULSE_GEN_STATUS_EN
    if (a == AW'(REG_STATUS))      return SEL_STATUS;
`endif
    return SEL_NONE;
  endfunction

  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old, input logic [DW-1:0] data,
                                               input logic [SW-1:0] strb);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < SW; i++) begin
      if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
    end
    return r;
  endfunction

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) live <= 1'b0;
    else                live <= 1'b1;
  end

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) wr_state <= IDLE;
    else                wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    unique case (wr_state)
      IDLE: begin
        if (aw_hs && w_hs) wr_next = RESP;
        else if (aw_hs)    wr_next = GOT_AW;
        else if (w_hs)     wr_next = GOT_W;
      end
      GOT_AW:  if (w_hs)         wr_next = RESP;
      GOT_W:   if (aw_hs)        wr_next = RESP;
      RESP:    if (S_AXI_BREADY) wr_next = IDLE;
      default: wr_next = IDLE;
    endcase
  end

  always_comb begin
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    unique case (wr_state)
      IDLE: begin
        S_AXI_AWREADY = live;
        S_AXI_WREADY  = live;
      end
      GOT_AW:  S_AXI_WREADY  = 1'b1;
      GOT_W:   S_AXI_AWREADY = 1'b1;
      RESP:    S_AXI_BVALID  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_word_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      if (aw_hs) aw_word_q <= S_AXI_AWADDR[AW-1:2];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
    end
  end

  // Commit on the edge the second half arrives, taking that half straight from the bus.
  assign wr_commit = (wr_state != RESP) && (wr_next == RESP);
  assign wr_word   = aw_hs ? S_AXI_AWADDR[AW-1:2] : aw_word_q;
  assign wr_data   = w_hs ? S_AXI_WDATA : wdata_q;
  assign wr_strb   = w_hs ? S_AXI_WSTRB : wstrb_q;
  assign wr_sel    = decode(wr_word);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ctrl_q      <= '0;
      period_q    <= '0;
      width_q     <= '0;
      limit_q     <= '0;
      S_AXI_BRESP <= RESP_OKAY;
    end else if (wr_commit) begin
      case (wr_sel)
        SEL_CTRL:   ctrl_q   <= apply_strb(ctrl_q, wr_data, wr_strb);
        SEL_PERIOD: period_q <= apply_strb(period_q, wr_data, wr_strb);
        SEL_WIDTH:  width_q  <= apply_strb(width_q, wr_data, wr_strb);
        SEL_LIMIT:  limit_q  <= apply_strb(limit_q, wr_data, wr_strb);
        default: ;
      endcase
      S_AXI_BRESP <= (wr_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  assign S_AXI_ARREADY = live && !S_AXI_RVALID;
  assign rd_sel        = decode(S_AXI_ARADDR[AW-1:2]);

  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      SEL_CTRL:   rd_mux = ctrl_q;
      SEL_PERIOD: rd_mux = period_q;
      SEL_WIDTH:  rd_mux = width_q;
      SEL_LIMIT:  rd_mux = limit_q;
`ifdef PULSE_GEN_STATUS_EN
      SEL_STATUS: rd_mux = {running, pulse_count};
`endif
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
    end else if (ar_hs) begin
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA  <= rd_mux;
      S_AXI_RRESP  <= (rd_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
    end else if (S_AXI_RVALID && S_AXI_RREADY) begin
      S_AXI_RVALID <= 1'b0;
    end
  end

  fpga_pulse_generator_core #(.W(DW)) u_core (
    .core_clk    (S_AXI_ACLK),
    .arst_n      (S_AXI_ARESETN),
    .enable      (ctrl_q[CTRL_ENABLE_BIT]),
    .period      (period_q),
    .width       (width_q),
    .count_limit (limit_q),
`ifdef PULSE_GEN_STATUS_EN
    .running     (running),
    .pulse_count (pulse_count),
`endif
    .pulse_out   (pulse_out)
  );

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_fpga_pulse_generator_axil_slave.sv
// Directed + randomized bench: register model with byte strobes, pulse train predicted from period/width/limit rules.
module tb_fpga_pulse_generator_axil_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [4:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        pulse_out;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] mregs[4];

  fpga_pulse_generator_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .pulse_out(pulse_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [41:0] all_outs();
    return {awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata, pulse_out};
  endfunction

  // Callers enter and leave these tasks at a negedge.
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp);
    bit aw_f, w_f, b_f, done;
    int n;
    done = 0; n = 0; resp = 2'bxx;
    awaddr = addr; awprot = 3'($urandom); wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    while (!done && n < 50) begin
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      b_f  = bvalid && bready;
      if (b_f) resp = bresp;
      @(negedge clk);
      n++;
      if (aw_f) awvalid = 1'b0;
      if (w_f)  wvalid = 1'b0;
      if (b_f) begin bready = 1'b0; done = 1; end
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    check("write_complete", done, 1);
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit ar_f, r_f, done;
    int n;
    done = 0; n = 0; data = 'x; resp = 2'bxx;
    araddr = addr; arprot = 3'($urandom); arvalid = 1'b1; rready = 1'b1;
    while (!done && n < 50) begin
      ar_f = arvalid && arready;
      r_f  = rvalid && rready;
      if (r_f) begin data = rdata; resp = rresp; end
      @(negedge clk);
      n++;
      if (ar_f) arvalid = 1'b0;
      if (r_f) begin rready = 1'b0; done = 1; end
    end
    arvalid = 1'b0; rready = 1'b0;
    check("read_complete", done, 1);
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [1:0] r;
    int idx;
    idx = int'(addr[4:2]);
    axi_write(addr, data, strb, r);
    if (idx < 4) begin
      check($sformatf("bresp_okay@%02h", addr), r, 2'b00);
      for (int b = 0; b < 4; b++) if (strb[b]) mregs[idx][8*b +: 8] = data[8*b +: 8];
    end else begin
      check($sformatf("bresp_slverr@%02h", addr), r, 2'b10);
    end
  endtask

  task automatic do_read(input logic [4:0] addr);
    logic [31:0] d;
    logic [1:0]  r;
    int idx;
    idx = int'(addr[4:2]);
    axi_read(addr, d, r);
    if (idx < 4) begin
      check($sformatf("rdata@%02h", addr), d, mregs[idx]);
      check($sformatf("rresp@%02h", addr), r, 2'b00);
    end else begin
      check($sformatf("rdata_unmapped@%02h", addr), d, 32'h0);
      check($sformatf("rresp_unmapped@%02h", addr), r, 2'b10);
    end
  endtask

  function automatic logic exp_pulse(input int k, input int p, input int w, input int n);
    if (p == 0) return 1'b0;
    if (n != 0 && (k / p) >= n) return 1'b0;
    return (k % p) < w;
  endfunction

  task automatic run_pulse(input int p, input int w, input int n, input string tag);
    int t, mism, win;
    bit found;
    do_write(5'h00, 32'h0, 4'hF);
    do_write(5'h04, 32'(p), 4'hF);
    do_write(5'h08, 32'(w), 4'hF);
    do_write(5'h0C, 32'(n), 4'hF);
    do_write(5'h00, 32'h1, 4'hF);
    mism = 0;
    if (p == 0) begin
      for (int k = 0; k < 20; k++) begin
        if (pulse_out !== 1'b0) mism++;
        @(negedge clk);
      end
      check({tag, "_idle"}, mism, 0);
    end else begin
      found = 0; t = 0;
      while (!found && t < 20) begin
        if (pulse_out === 1'b1) found = 1;
        else begin @(negedge clk); t++; end
      end
      check({tag, "_start"}, found, 1);
      check({tag, "_latency_le2"}, (t <= 2), 1);
      if (found) begin
        win = (n == 0) ? 3 * p + 12 : n * p + 12;
        for (int k = 0; k < win; k++) begin
          if (pulse_out !== exp_pulse(k, p, w, n)) mism++;
          @(negedge clk);
        end
        check({tag, "_train_mismatches"}, mism, 0);
      end
    end
  endtask

  initial begin
    logic [31:0] old_v, new_v;
    int hi;
    logic [4:0] a;
    int base[7] = '{0, 4, 8, 12, 20, 24, 28};
    int p, w, n;

    foreach (mregs[i]) mregs[i] = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outs(), 42'h0);
    rst_n = 1'b1;
    #1 check("ready_low_at_deassert", {awready, wready, arready}, 3'b000);
    @(negedge clk);
    check("ready_high_after_clock", {awready, wready, arready}, 3'b111);

    // Basic write/readback of all four registers.
    do_write(5'h00, 32'h1, 4'hF);
    do_write(5'h04, 32'h2, 4'hF);
    do_write(5'h08, 32'h3, 4'hF);
    do_write(5'h0C, 32'h4, 4'hF);
    for (int i = 0; i < 4; i++) do_read(5'(i * 4));
    do_write(5'h00, 32'h0, 4'hF);

    // AW three cycles ahead of W, BREADY held low five cycles.
    awaddr = 5'h08; awvalid = 1'b1; bready = 1'b0;
    check("aw_first_ready", awready, 1);
    @(negedge clk); awvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("aw_latched_ready_pattern", {awready, wready}, 2'b01);
    wdata = 32'h5A5A1234; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk); wvalid = 1'b0;
    mregs[2] = 32'h5A5A1234;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bvalid_held_%0d", i), {bvalid, bresp, awready, wready}, 5'b10000);
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk); bready = 1'b0;
    check("bvalid_dropped", bvalid, 0);
    do_read(5'h08);

    // Byte strobes and empty strobe.
    do_write(5'h04, 32'h0, 4'hF);
    do_write(5'h04, 32'hAABBCCDD, 4'b0101);
    check("strobe_model_value", mregs[1], 32'h00BB00DD);
    do_read(5'h04);
    do_write(5'h04, 32'hFFFFFFFF, 4'b0000);
    do_read(5'h04);

    // Unmapped address leaves everything unchanged.
    do_read(5'h14);
    do_write(5'h14, 32'hDEADBEEF, 4'hF);
    for (int i = 0; i < 4; i++) do_read(5'(i * 4));

    // Simultaneous read and write of WIDTH returns pre-write value.
    old_v = mregs[2]; new_v = $urandom;
    awaddr = 5'h08; wdata = new_v; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    araddr = 5'h08; arvalid = 1'b1; rready = 1'b1;
    check("simul_ready", {awready, wready, arready}, 3'b111);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("simul_rdata_prewrite", {rvalid, rresp, rdata}, {1'b1, 2'b00, old_v});
    check("simul_bresp", {bvalid, bresp}, 3'b100);
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    mregs[2] = new_v;
    do_read(5'h08);

    // Randomized register traffic, low address bits and PROT ignored.
    for (int i = 0; i < 24; i++) begin
      a = 5'(base[$urandom_range(0, 6)]) | 5'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) do_write(a, $urandom, 4'($urandom));
      else                            do_read(a);
    end

    // Pulse engine.
    run_pulse(10, 3, 2, "train_10_3_2");
    for (int i = 0; i < 3; i++) begin
      p = $urandom_range(1, 12);
      w = $urandom_range(1, p + 2);
      n = $urandom_range(1, 3);
      run_pulse(p, w, n, $sformatf("train_%0d_%0d_%0d", p, w, n));
    end
    run_pulse(0, 3, 0, "train_period0");
    run_pulse(6, 2, 0, "train_freerun");
    do_write(5'h00, 32'h0, 4'hF);
    hi = 0;
    for (int k = 0; k < 10; k++) begin
      if (pulse_out !== 1'b0) hi++;
      @(negedge clk);
    end
    check("disable_forces_low", hi, 0);

    // Reset in the middle of a write with a pending response.
    do_write(5'h04, 32'h5, 4'hF);
    do_write(5'h00, 32'h1, 4'hF);
    awaddr = 5'h04; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("bvalid_pending_before_reset", bvalid, 1);
    #2 rst_n = 1'b0;
    #1 check("outputs_cleared_async", all_outs(), 42'h0);
    foreach (mregs[i]) mregs[i] = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("no_ready_at_release", {awready, wready, arready, bvalid}, 4'b0000);
    @(negedge clk);
    check("post_reset_idle", {awready, wready, arready, bvalid, rvalid}, 5'b11100);
    do_read(5'h04);
    check("post_reset_pulse_low", pulse_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
